// File: rtl/ofm_drain_pkg.sv
// Shared types and constants for the output-feature-map drain engine.
package ofm_drain_pkg;

  // Drain controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Packed partial-sum lanes per buffer word (DATA_W / LANE_W).
  localparam int OFM_LANES = 4;

endpackage

// File: rtl/ofm_skid_fifo.sv
// Two-entry fall-through FIFO between the output-buffer read port and the
// stream interface. When empty, an arriving word is presented immediately
// so the stream sees it in the same cycle it leaves the buffer.
module ofm_skid_fifo #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drain;

  assign empty      = (count_q == 2'd0);
  assign rd_valid_o = !empty || wr_en_i;
  assign pop        = rd_valid_o && rd_ready_i;
  // A word bypassed straight to the consumer is never stored.
  assign push       = wr_en_i && !(empty && pop);
  assign drain      = pop && !empty;
  assign count_o    = count_q;

  // Present the head entry, or the incoming word when the FIFO is empty.
  always_comb begin
    if (!empty) begin
      rd_data_o = mem_q[rd_ptr_q];
    end else if (wr_en_i) begin
      rd_data_o = wr_data_i;
    end else begin
      rd_data_o = '0;
    end
  end

  // Occupancy after this cycle's push and drain.
  always_comb begin
    count_d = count_q;
    if (push && !drain) begin
      count_d = count_q + 2'd1;
    end else if (drain && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push)  wr_ptr_q <= ~wr_ptr_q;
      if (drain) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Data storage.
  // NOTE: storage has no reset; it is only observed through count_q, which is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ofm_drain.sv
// Output-feature-map drain: reads word_count words from the output buffer
// starting at base_addr and streams them out with valid/ready and a last flag.
// Optional build macro OFM_DRAIN_RELU_EN clamps negative lanes to zero.
module ofm_drain
  import ofm_drain_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int LANE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]       rd_left_q, rd_left_d;
  logic [15:0]       xfer_left_q, xfer_left_d;
  logic              inflight_q;
  logic [1:0]        fifo_count;
  logic [1:0]        occupancy;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;
  logic              xfer;

  // Only issue a read when the word it returns is guaranteed a FIFO slot.
  assign occupancy = fifo_count + {1'b0, inflight_q};
  assign xfer      = m_valid && m_ready;
  assign rd_addr   = rd_addr_q;
  assign m_valid   = fifo_valid;
  assign m_last    = fifo_valid && (xfer_left_q == 16'd1);

  // Next-state, read issue and status decode.
  // NOTE: every output and _d signal gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_left_d   = rd_left_q;
    xfer_left_d = xfer_left_q;
    rd_en       = 1'b0;
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;
    if (xfer) begin
      xfer_left_d = xfer_left_q - 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_addr_d   = base_addr;
          rd_left_d   = word_count;
          xfer_left_d = word_count;
          state_d     = (word_count == 16'd0) ? ST_FIN : ST_READ;
        end
      end
      ST_READ: begin
        if (occupancy < 2'd2) begin
          rd_en     = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          rd_left_d = rd_left_q - 16'd1;
          if (rd_left_q == 16'd1) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (xfer && m_last) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state, address counter and word counters.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      rd_left_q   <= 16'd0;
      xfer_left_q <= 16'd0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      xfer_left_q <= xfer_left_d;
      inflight_q  <= rd_en;
    end
  end

  ofm_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (inflight_q),
    .wr_data_i  (rd_data),
    .rd_ready_i (m_ready),
    .rd_valid_o (fifo_valid),
    .rd_data_o  (fifo_data),
    .count_o    (fifo_count)
  );

  // Per-lane output path; ReLU clamps negative two's-complement lanes when enabled.
  for (genvar i = 0; i < OFM_LANES; i++) begin : g_lane
    logic [LANE_W-1:0] lane;
    assign lane = fifo_data[i*LANE_W +: LANE_W];
`ifdef OFM_DRAIN_RELU_EN
    assign m_data[i*LANE_W +: LANE_W] = lane[LANE_W-1] ? '0 : lane;
`else
    assign m_data[i*LANE_W +: LANE_W] = lane;
`endif
  end

endmodule

// File: tb/tb_ofm_drain.sv
// Directed testbench for ofm_drain: table of layer drains plus hand-written
// reset sequences. A small buffer model supplies read data one cycle after rd_en.
module tb_ofm_drain;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam int LANE_W = 16;

`ifdef OFM_DRAIN_RELU_EN
  localparam logic [63:0] RELU_WORD_EXP = 64'h0000_7FFF_0000_0001;
`else
  localparam logic [63:0] RELU_WORD_EXP = 64'h8000_7FFF_FFFF_0001;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [15:0]       word_count = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  ofm_drain #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Buffer contents as a function of address; 0x0100 holds the ReLU probe word.
  function automatic logic [63:0] mem_word(input logic [15:0] a);
    if (a == 16'h0100) return 64'h8000_7FFF_FFFF_0001;
    return {a ^ 16'h8000, a, ~a, a + 16'h1234};
  endfunction

  function automatic logic [63:0] relu(input logic [63:0] w);
    logic [63:0] r;
    r = w;
`ifdef OFM_DRAIN_RELU_EN
    for (int i = 0; i < 4; i++) begin
      if (w[i*16+15]) r[i*16 +: 16] = 16'h0000;
    end
`endif
    return r;
  endfunction

  // Output-buffer read port model: data valid the cycle after rd_en.
  always @(posedge clk) begin
    rd_data <= rd_en ? mem_word(rd_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_en"},   64'(rd_en),   64'd0);
    check({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, " m_valid"}, 64'(m_valid), 64'd0);
    check({tag, " m_data"},  m_data,       64'd0);
    check({tag, " m_last"},  64'(m_last),  64'd0);
    check({tag, " busy"},    64'(busy),    64'd0);
    check({tag, " done"},    64'(done),    64'd0);
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] wc;
    bit          toggle;     // m_ready high only on odd cycles
    int          restart_at; // cycle to pulse a spurious start (0 = none)
    int          exp_first;  // cycle of first m_valid (-1 = never)
    int          exp_done;   // cycle of the done pulse
    bit          chk_word0;
    logic [63:0] exp_word0;
  } vec_t;

  // Drive one layer; cycle k is the k-th cycle after the start cycle.
  task automatic run_layer(input vec_t v, input string tag);
    int          rd_cnt = 0;
    int          xf_cnt = 0;
    int          first = -1;
    int          done_at = -1;
    bit          stalled = 1'b0;
    logic [63:0] held_data = '0;
    logic        held_last = 1'b0;
    logic [15:0] exp_addr;
    logic [15:0] word_addr;
    @(negedge clk);
    base_addr  = v.base;
    word_count = v.wc;
    m_ready    = 1'b1;
    start      = 1'b1;
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      @(negedge clk);
      start      = 1'b0;
      base_addr  = 16'h0000;
      word_count = 16'd0;
      m_ready    = v.toggle ? (k % 2 == 1) : 1'b1;
      if (k == v.restart_at) begin
        start      = 1'b1;
        base_addr  = 16'h9999;
        word_count = 16'd3;
      end
      #1;
      check({tag, " busy"}, 64'(busy), 64'd1);
      if (stalled) begin
        check({tag, " stall valid"}, 64'(m_valid), 64'd1);
        check({tag, " stall data"},  m_data,       held_data);
        check({tag, " stall last"},  64'(m_last),  64'(held_last));
      end
      if (m_valid && first < 0) first = k;
      if (rd_en) begin
        exp_addr = v.base + 16'(rd_cnt);
        check({tag, " rd_addr"}, 64'(rd_addr), 64'(exp_addr));
        rd_cnt++;
      end
      if (m_valid && m_ready) begin
        word_addr = v.base + 16'(xf_cnt);
        check({tag, " m_data"}, m_data, relu(mem_word(word_addr)));
        check({tag, " m_last"}, 64'(m_last), 64'(xf_cnt + 1 == int'(v.wc)));
        if (v.chk_word0 && xf_cnt == 0) check({tag, " relu word"}, m_data, v.exp_word0);
        xf_cnt++;
      end
      stalled   = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      if (done) done_at = k;
    end
    check({tag, " done cycle"},  64'(done_at), 64'(v.exp_done));
    check({tag, " first valid"}, 64'(first),   64'(v.exp_first));
    check({tag, " reads"},       64'(rd_cnt),  64'(v.wc));
    check({tag, " transfers"},   64'(xf_cnt),  64'(v.wc));
    @(negedge clk);
    #1;
    check({tag, " busy after"}, 64'(busy), 64'd0);
    check({tag, " done after"}, 64'(done), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h0010, 16'd4, 1'b0, 0, 2, 6,  1'b0, 64'h0};
    vecs[1] = '{16'h0000, 16'd0, 1'b0, 0, -1, 1, 1'b0, 64'h0};
    vecs[2] = '{16'hFFFE, 16'd3, 1'b0, 3, 2, 5,  1'b0, 64'h0};
    vecs[3] = '{16'h0200, 16'd8, 1'b1, 5, 2, 18, 1'b0, 64'h0};
    vecs[4] = '{16'h0100, 16'd1, 1'b0, 0, 2, 3,  1'b1, RELU_WORD_EXP};

    // Power-up reset.
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_layer(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort a 6-word layer after two transfers.
    @(negedge clk);
    base_addr  = 16'h0040;
    word_count = 16'd6;
    m_ready    = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("abort hold done", 64'(done), 64'd0);
      check("abort hold busy", 64'(busy), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_layer('{16'h0050, 16'd2, 1'b0, 0, 2, 4, 1'b0, 64'h0}, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofm_drain.md
OFM_DRAIN -- requirements
Module: ofm_drain

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, output-buffer address width.
REQ-002 SHALL have parameter DATA_W, default 64, buffer word width (4 packed 16-bit lanes).
REQ-003 SHALL have parameter LANE_W, default 16, width of one packed partial-sum lane.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse, begin draining a layer (driven from layer_ready).
REQ-007 SHALL have port base_addr  input  ADDR_W  first output-buffer address, sampled on accepted start.
REQ-008 SHALL have port word_count  input  16  number of words to drain, sampled on accepted start.
REQ-009 SHALL have port rd_en  output  1  output-buffer read-port enable.
REQ-010 SHALL have port rd_addr  output  ADDR_W  output-buffer read address.
REQ-011 SHALL have port rd_data  input  DATA_W  output-buffer read data, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port m_valid  output  1  stream word valid.
REQ-013 SHALL have port m_ready  input  1  downstream ready.
REQ-014 SHALL have port m_data  output  DATA_W  stream word.
REQ-015 SHALL have port m_last  output  1  high with the final word of the layer.
REQ-016 SHALL have port busy  output  1  high from accepted start until done.
REQ-017 SHALL have port done  output  1  one-cycle pulse after the last word transfers.

Function
REQ-018 FSM states SHALL be IDLE, READ, FLUSH, FIN.
- IDLE -> READ on start when word_count != 0.
- IDLE -> FIN on start when word_count == 0; no reads issued.
- READ -> FLUSH when the last read issues.
- FLUSH -> FIN when the last word transfers (m_valid & m_ready & m_last).
- FIN -> IDLE unconditionally; done is high in FIN.
REQ-019 start SHALL be ignored in any state other than IDLE.
REQ-020 A word SHALL transfer only on a cycle with m_valid & m_ready; m_data and m_last SHALL hold stable while m_valid & !m_ready.
REQ-021 Read data SHALL land in a 2-entry FIFO. A read SHALL issue only when FIFO occupancy plus in-flight reads is below 2, so no data is lost under backpressure.
REQ-022 With m_ready held high, throughput SHALL be 1 word/cycle; the first m_valid SHALL occur 2 cycles after the accepted start.
REQ-023 rd_addr SHALL begin at base_addr and increment by 1 per issued read, wrapping modulo 2^ADDR_W.
REQ-024 Exactly word_count reads and word_count stream transfers SHALL occur per layer, in address order.
REQ-025 m_last SHALL be asserted only on transfer number word_count.
REQ-026 rd_en SHALL be low outside READ.

Reset
REQ-027 While rst_n is low, the following SHALL hold: state IDLE, FIFO empty, in-flight count 0, and rd_en, m_valid, m_last, busy, done all 0; rd_addr and m_data 0.
REQ-028 Reset asserted mid-layer SHALL abort the layer without a done pulse; the next start after release SHALL behave as from power-up.

Configuration
REQ-029 With OFM_DRAIN_RELU_EN defined, each LANE_W lane of m_data SHALL be treated as two's complement, and negative lanes SHALL be output as 0. ReLU SHALL be applied at the FIFO output, with no added latency.
REQ-030 Without OFM_DRAIN_RELU_EN, m_data SHALL equal rd_data bit-exactly.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the lane count constant (DATA_W/LANE_W = 4).
REQ-032 The 2-entry FIFO SHALL be one sub-module, ofm_skid_fifo; the address counter and FSM stay in ofm_drain.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- start, base_addr=0x0010, word_count=4, m_ready=1 -> reads 0x10..0x13 on consecutive cycles; 4 transfers; m_last on the 4th; done 1 cycle later.
- word_count=0 -> no rd_en; busy for 1 cycle; done pulse in the cycle after start.
- base_addr=0xFFFE, word_count=3 -> rd_addr sequence FFFE, FFFF, 0000.
- m_ready toggled 1/0 every cycle, word_count=8 -> all 8 words in order, none lost or duplicated; m_data stable while stalled.
- ReLU enabled, rd_data=0x8000_7FFF_FFFF_0001 -> m_data=0x0000_7FFF_0000_0001; disabled -> unchanged.
- rst_n low mid-layer (after 2 of 6 words) -> all outputs 0, no done; a fresh start of 2 words then completes normally.
